// File: rtl/sum_accumulator.sv
// sum_accumulator
//   First registered stage after the 2-bit adder (Sumator). Accepts IN_W-bit
//   sums over a valid/ready handshake and accumulates N_SAMPLES of them. It
//   then presents the total, modulo 2^ACC_W, together with a sticky overflow
//   flag. The result stays on the outputs until the consumer takes it.
//
// Ports
//   clk        in          rising-edge clock
//   rst_n      in          asynchronous active-low reset
//   clear      in          synchronous abort: drop partial sum, return to IDLE
//   in_valid   in          in_data valid
//   in_ready   out         stage can accept in_data this cycle
//   in_data    in  IN_W    unsigned sum from the adder
//   out_valid  out         out_sum/out_ovf valid
//   out_ready  in          consumer accepts the result this cycle
//   out_sum    out ACC_W   accumulated total, modulo 2^ACC_W
//   out_ovf    out         a carry out of ACC_W occurred during this result
//   busy       out         high while accumulating or holding a result
module sum_accumulator #(
  parameter int IN_W      = 3,
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_rdy_en;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  logic             w_accept;
  logic [ACC_W:0]   w_din_ext;
  logic [ACC_W:0]   w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;

  // r_rdy_en holds in_ready low from reset assertion until the first clock
  // edge after release.
  assign in_ready  = r_rdy_en & (r_state != S_HOLD);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign busy      = (r_state != S_IDLE);

  // In IDLE the accumulator and overflow flag start fresh from this beat.
  assign w_din_ext  = {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign w_base     = (r_state == S_ACC) ? {1'b0, r_acc} : '0;
  assign w_sum      = w_base + w_din_ext;
  assign w_ovf_next = ((r_state == S_ACC) & r_ovf) | w_sum[ACC_W];
  assign w_cnt_next = r_cnt + CNT_W'(1);
  // r_cnt is 0 in IDLE, so N_SAMPLES==1 finishes on the first beat.
  assign w_last     = (r_cnt == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (clear) begin
        r_state     <= S_IDLE;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_sum   <= '0;
        r_out_ovf   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_ACC: begin
            if (w_accept) begin
              r_acc <= w_sum[ACC_W-1:0];
              r_ovf <= w_ovf_next;
              r_cnt <= w_cnt_next;
              if (w_last) begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum[ACC_W-1:0];
                r_out_ovf   <= w_ovf_next;
              end else begin
                r_state <= S_ACC;
              end
            end
          end
          S_HOLD: begin
            if (out_ready) begin
              r_state     <= S_IDLE;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_sum   <= '0;
              r_out_ovf   <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

  localparam int N = 16;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  logic       s6_clear, s6_valid, s6_ready, s6_ovalid, s6_oready, s6_ovf, s6_busy;
  logic [2:0] s6_data;
  logic [5:0] s6_sum;

  logic       s1_clear, s1_valid, s1_ready, s1_ovalid, s1_oready, s1_ovf, s1_busy;
  logic [2:0] s1_data;
  logic [7:0] s1_sum;

  int vectors;
  int miscompares;

  // Reference view: number of beats taken and their plain integer total.
  int m_n;
  int m_total;
  bit m_hold;
  bit m_rdy;

  sum_accumulator #(.IN_W(3), .ACC_W(8), .N_SAMPLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  sum_accumulator #(.IN_W(3), .ACC_W(6), .N_SAMPLES(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(s6_clear),
    .in_valid(s6_valid), .in_ready(s6_ready), .in_data(s6_data),
    .out_valid(s6_ovalid), .out_ready(s6_oready),
    .out_sum(s6_sum), .out_ovf(s6_ovf), .busy(s6_busy)
  );

  sum_accumulator #(.IN_W(3), .ACC_W(8), .N_SAMPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(s1_clear),
    .in_valid(s1_valid), .in_ready(s1_ready), .in_data(s1_data),
    .out_valid(s1_ovalid), .out_ready(s1_oready),
    .out_sum(s1_sum), .out_ovf(s1_ovf), .busy(s1_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the main instance, called at posedge+1.
  task automatic step(input bit v, input logic [2:0] d, input bit ordy, input bit clr);
    bit acc;
    in_valid  = v;
    in_data   = v ? d : 3'bx;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    check("in_ready",  in_ready,  m_rdy && !m_hold);
    check("out_valid", out_valid, m_hold);
    check("out_sum",   out_sum,   m_hold ? (m_total % 256) : 0);
    check("out_ovf",   out_ovf,   m_hold && (m_total >= 256));
    check("busy",      busy,      m_hold || (m_n > 0));
    acc = v && m_rdy && !m_hold;
    @(posedge clk);
    m_rdy = 1'b1;
    if (clr) begin
      m_hold = 1'b0; m_n = 0; m_total = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0; m_n = 0; m_total = 0;
      end
    end else if (acc) begin
      m_total += int'(d);
      m_n++;
      if (m_n == N) m_hold = 1'b1;
    end
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_n = 0; m_total = 0; m_hold = 1'b0; m_rdy = 1'b0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s6_clear = 1'b0; s6_valid = 1'b0; s6_data = '0; s6_oready = 1'b0;
    s1_clear = 1'b0; s1_valid = 1'b0; s1_data = '0; s1_oready = 1'b0;

    // Reset values while rst_n is low.
    #2;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_busy",      busy,      0);
    #6 rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // T2: every Sumator sum a+b, then T4 backpressure while holding.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        step(1, 3'(a + b), 0, 0);
    step(0, 0, 0, 0);
    check("t2_sum", out_sum, 48);
    check("t2_ovf", out_ovf, 0);
    for (int i = 0; i < 10; i++) step(1, 3'($urandom_range(0, 7)), 0, 0);
    check("t4_sum_stable", out_sum, 48);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // T5: random gaps, sixteen beats of 5.
    for (int g = 0; g < 200 && !m_hold; g++) step(($urandom % 2) == 1, 3'd5, 0, 0);
    step(0, 0, 0, 0);
    check("t5_valid", out_valid, 1);
    check("t5_sum", out_sum, 80);
    step(0, 0, 1, 0);

    // T6: clear at cnt=9 with a concurrent beat, then sixteen beats of 1.
    for (int i = 0; i < 9; i++) step(1, 3'd3, 0, 0);
    step(1, 3'd1, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 3'd1, 0, 0);
    step(0, 0, 0, 0);
    check("t6_sum", out_sum, 16);
    step(0, 0, 1, 0);

    // T1: asynchronous reset mid-burst at cnt=5.
    for (int i = 0; i < 5; i++) step(1, 3'd4, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_in_ready", in_ready, 0);
    check("t1_busy", busy, 0);
    check("t1_out_valid", out_valid, 0);
    check("t1_out_sum", out_sum, 0);
    m_n = 0; m_total = 0; m_hold = 1'b0; m_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    check("t1_ready_after", in_ready, 1);
    for (int i = 0; i < 16; i++) step(1, 3'd7, 0, 0);
    step(0, 0, 0, 0);
    check("t1_fresh_sum", out_sum, 112);
    step(0, 0, 1, 0);

    // Randomised traffic against the reference view.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 3'($urandom_range(0, 7)), ($urandom % 2) == 1,
           ($urandom % 60) == 0);

    // T3: ACC_W=6, sixteen beats of 7 wrap to 112 mod 64 with overflow.
    for (int i = 0; i < 16; i++) begin
      s6_valid = 1'b1; s6_data = 3'd7;
      @(posedge clk); #1;
    end
    s6_valid = 1'b0; s6_data = 3'bx;
    @(negedge clk);
    check("t3_valid", s6_ovalid, 1);
    check("t3_sum", s6_sum, (16 * 7) % 64);
    check("t3_ovf", s6_ovf, 1);
    check("t3_busy", s6_busy, 1);
    check("t3_in_ready", s6_ready, 0);
    s6_oready = 1'b1;
    @(posedge clk); #1;
    s6_oready = 1'b0;
    @(negedge clk);
    check("t3_idle_valid", s6_ovalid, 0);
    check("t3_idle_ovf", s6_ovf, 0);

    // T6: N_SAMPLES=1, a single beat of 6 is the result the next clock.
    @(posedge clk); #1;
    s1_valid = 1'b1; s1_data = 3'd6;
    @(posedge clk); #1;
    s1_valid = 1'b0;
    @(negedge clk);
    check("n1_valid", s1_ovalid, 1);
    check("n1_sum", s1_sum, 6);
    check("n1_ovf", s1_ovf, 0);
    check("n1_in_ready", s1_ready, 0);
    check("n1_busy", s1_busy, 1);
    s1_oready = 1'b1;
    @(posedge clk); #1;
    s1_oready = 1'b0;
    @(negedge clk);
    check("n1_idle_valid", s1_ovalid, 0);
    check("n1_idle_sum", s1_sum, 0);
    check("n1_idle_ready", s1_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
